pipe_unscale: RTL
=================

# pipe_unscale

Inverse stage for the scaling pipe. It accepts a pair of scaled 16-bit samples plus the 2-bit coefficient they were scaled by, and recovers the pre-scale values by integer division. Division is done by two parallel iterative restoring dividers, one per lane. It sits downstream of the scaling pipe in loopback and scoreboard paths, where it checks that the scaled data is invertible. Input and output both use a valid/ready handshake.

## Interface
- WIDTH, 16: sample width per lane. All behaviour below assumes 16; the counter width is derived as $clog2(WIDTH).
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_cf  input  2  coefficient; sampled on accept.
- i_valid  input  1  input pair valid.
- o_ready  output  1  block can accept; high only in IDLE.
- i_data0  input  WIDTH  lane 0 scaled sample.
- i_data1  input  WIDTH  lane 1 scaled sample.
- o_valid  output  1  result pair valid.
- i_ready  input  1  downstream accepts the result.
- o_data0  output  WIDTH  lane 0 recovered sample.
- o_data1  output  WIDTH  lane 1 recovered sample.
- o_err  output  2  per-lane flag: bit n set means lane n was not exactly invertible.

## Operation
- **States:** IDLE, DIV, DONE. Reset state is IDLE.
- **Accept:** happens on a rising edge where state==IDLE and i_valid && o_ready.
  - Captures i_cf, i_data0, i_data1.
  - Clears the bit counter and both partial remainders.
  - Moves to DIV.
- **DIV:** each edge produces one quotient bit per lane, MSB first (restoring divide).
  - Shift the remainder left, bringing in the next dividend bit.
  - If remainder >= {14'b0, cf}: subtract, quotient bit = 1; otherwise quotient bit = 0.
  - When the counter reaches WIDTH-1, the next edge moves to DONE and loads the outputs.
- **Per-lane result rules,** applied when the outputs are loaded, in this priority:
  - Captured sample == 16'h0000 or 16'hFFFF: output = sample, err = 0 (pass-through markers).
  - Else if cf == 0: output = 16'hFFFF, err = 1 (divide by zero).
  - Else: output = quotient; err = 1 if the final remainder is non-zero, else 0.
- **Fixed latency:** the dividers run the full WIDTH cycles for every case, including pass-through and cf==0.
- **DONE:**
  - o_valid = 1; o_data0/1 and o_err are stable.
  - On an edge with i_ready = 1, go to IDLE; o_valid falls after that edge.
  - While i_ready = 0, stay in DONE indefinitely with outputs held.
- **Input side during a transaction:** o_ready = 0 in DIV and DONE; i_valid and the inputs are ignored there.
- **No overlap:** the next accept is possible at the earliest one edge after the DONE→IDLE edge.
- **Output holding:** o_data0/1 and o_err keep their last values through IDLE and DIV. They are updated only on the load into DONE.

## Timing
- **Reset values** (while rst_n = 0, asynchronously):
  - state = IDLE.
  - o_ready = 0 (registered), o_valid = 0.
  - o_data0 = o_data1 = 0, o_err = 0.
  - Counter and remainders = 0.
- **Out of reset:** o_ready rises on the first rising edge after rst_n deasserts.
- **Latency:** with accept at edge E0, o_valid rises after edge E16 (WIDTH edges).
- **Handshake edges:**
  - DONE→IDLE happens on the first edge with i_ready = 1; o_ready rises on that same edge.
  - If i_ready is already 1 when o_valid rises, o_valid lasts exactly one cycle.
- **Throughput:** one pair per 18 cycles with no backpressure.
  - Edges: accept at E0, DONE at E16, IDLE at E17, next accept at E18.
- **Reset mid-operation** (DIV or DONE):
  - Everything returns to the reset values immediately and the transaction is dropped.
  - There is no partial output and no o_valid pulse after reset is released.
- **Simultaneous events:**
  - i_valid arriving in the same cycle as the DONE→IDLE transition is not accepted. o_ready is still 0 in that cycle; acceptance happens on the following edge.
  - i_cf changing during DIV has no effect.

## Test plan
- **Exact divide:** reset, then accept cf=3, d0=0x0030, d1=0x5553.
  - Expect: o_data0=0x0010, o_data1=0x1C71, o_err=2'b00.
  - Expect: o_valid rises exactly 16 edges after accept.
- **Remainder and markers:** cf=2, d0=0x0007, d1=0xFFFF.
  - Expect: o_data0=0x0003, o_data1=0xFFFF, o_err=2'b01.
  - Then cf=1, d0=0x0000, d1=0x1234. Expect: 0x0000, 0x1234, o_err=2'b00.
- **Divide by zero:** cf=0, d0=0x0005, d1=0xFFFF.
  - Expect: o_data0=0xFFFF, o_data1=0xFFFF, o_err=2'b01.
- **Backpressure:** hold i_ready=0 for 10 cycles after o_valid rises.
  - Expect: outputs held and o_ready=0 throughout; a pulsed i_valid with new data is ignored.
  - Raise i_ready. Expect: o_valid falls after one edge, and o_ready is high from that edge.
- **Reset mid-DIV:** assert rst_n=0 eight edges after accept.
  - Expect: immediate o_ready=0, o_valid=0, and all data/err outputs = 0.
  - After release: o_ready=1 after one edge, and no spurious o_valid.
- **Back-to-back stream:** 4 pairs with i_valid and i_ready held high.
  - Expect: accepts 18 edges apart and results matching the reference-model quotient for every pair.

Source files
------------

// File: rtl/pipe_unscale_if.sv
// Handshake bundle for pipe_unscale: input pair + coefficient, output pair + per-lane error.
// Signal names follow the block's own view (i_* driven into it, o_* driven by it).
interface pipe_unscale_if #(
    parameter int unsigned WIDTH = 16
);
    logic [1:0]       i_cf;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data0;
    logic [WIDTH-1:0] i_data1;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data0;
    logic [WIDTH-1:0] o_data1;
    logic [1:0]       o_err;

    modport master (
        output i_cf, i_valid, i_data0, i_data1, i_ready,
        input  o_ready, o_valid, o_data0, o_data1, o_err
    );

    modport slave (
        input  i_cf, i_valid, i_data0, i_data1, i_ready,
        output o_ready, o_valid, o_data0, o_data1, o_err
    );
endinterface

// File: rtl/pipe_unscale.sv
// Inverse of the scaling pipe: two lock-stepped restoring dividers recover the pre-scale samples
// and flag any lane whose value was not an exact multiple of the coefficient.
module pipe_unscale #(
    parameter int unsigned WIDTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    pipe_unscale_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       cf_q, cf_d;
    logic [WIDTH-1:0] smp_q [2];
    logic [WIDTH-1:0] smp_d [2];
    logic [WIDTH-1:0] rem_q [2];
    logic [WIDTH-1:0] rem_d [2];
    logic [WIDTH-1:0] quo_q [2];
    logic [WIDTH-1:0] quo_d [2];
    logic [WIDTH-1:0] res_q [2];
    logic [WIDTH-1:0] res_d [2];
    logic [1:0]       err_q, err_d;
    logic             ready_q, ready_d;

    logic [CntW-1:0]  bit_idx;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem_sh [2];
    logic [WIDTH-1:0] rem_nx [2];
    logic [WIDTH-1:0] quo_nx [2];
    logic             accept;

    assign accept  = (state_q == StIdle) && bus.i_valid && ready_q;
    assign bit_idx = CntW'(WIDTH - 1) - cnt_q;
    assign divisor = {{(WIDTH-2){1'b0}}, cf_q};

    // One restoring-divide step per lane, dividend consumed MSB first.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            rem_sh[n] = {rem_q[n][WIDTH-2:0], smp_q[n][bit_idx]};
            rem_nx[n] = rem_sh[n];
            quo_nx[n] = {quo_q[n][WIDTH-2:0], 1'b0};
            if (rem_sh[n] >= divisor) begin
                rem_nx[n] = rem_sh[n] - divisor;
                quo_nx[n] = {quo_q[n][WIDTH-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cf_d    = cf_q;
        smp_d   = smp_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cf_d     = bus.i_cf;
                    smp_d[0] = bus.i_data0;
                    smp_d[1] = bus.i_data1;
                    cnt_d    = '0;
                    rem_d[0] = '0;
                    rem_d[1] = '0;
                    quo_d[0] = '0;
                    quo_d[1] = '0;
                    state_d  = StDiv;
                end
            end
            StDiv: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    // All-zeros/all-ones are markers and bypass the divide.
                    for (int n = 0; n < 2; n++) begin
                        if (smp_q[n] == '0 || smp_q[n] == '1) begin
                            res_d[n] = smp_q[n];
                            err_d[n] = 1'b0;
                        end else if (cf_q == 2'd0) begin
                            res_d[n] = '1;
                            err_d[n] = 1'b1;
                        end else begin
                            res_d[n] = quo_nx[n];
                            err_d[n] = |rem_nx[n];
                        end
                    end
                end
            end
            StDone: begin
                if (bus.i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cf_q    <= '0;
            smp_q   <= '{default: '0};
            rem_q   <= '{default: '0};
            quo_q   <= '{default: '0};
            res_q   <= '{default: '0};
            err_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cf_q    <= cf_d;
            smp_q   <= smp_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = (state_q == StDone);
    assign bus.o_data0 = res_q[0];
    assign bus.o_data1 = res_q[1];
    assign bus.o_err   = err_q;
endmodule
